pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock domain; reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 j, jAdx  in  1, 32  decode-stage jump request and target.
REQ-005 JR, JRAdx  in  1, 32  decode-stage jump-register request and target.
REQ-006 br, z, brAdx  in  1, 1, 32  execute-stage branch, zero flag and branch offset; taken = br & ~z.
REQ-007 haz  in  1  load-use hazard, stall request from hazard unit.
REQ-008 imem_ready  in  1  instruction memory accepts a new fetch this cycle.
REQ-009 PCWr  out  1  PC register write enable.
REQ-010 pc_sel  out  2  PC source: 00 sequential, 01 jump, 10 JR, 11 branch.
REQ-011 redir_adx  out  32  target for the PC register; 0 when pc_sel=00.
REQ-012 flush_if, flush_id, stall_if_id  out  1 each  pipeline control to IF/ID and ID/EX registers.
REQ-013 state  out  2  FSM state, for debug.
REQ-014 stall_cnt, redir_cnt  out  16 each  performance counters.

Function
REQ-015 SHALL implement states IDLE(00), RUN(01), WAIT_MEM(10) and HAZ_STALL(11).
REQ-016 IDLE: all control outputs 0; unconditional transition to RUN on the next clk.
REQ-017 Redirect priority SHALL be taken branch > JR > j; lower-priority requests in the same cycle are dropped.
REQ-018 RUN, imem_ready=1, no haz: PCWr=1; pc_sel and redir_adx follow the winning request combinationally, otherwise pc_sel=00.
REQ-019 Taken branch SHALL assert flush_if and flush_id in the same cycle; j or JR SHALL assert flush_if only.
REQ-020 RUN, imem_ready=0: PCWr=0; any winning redirect is latched into the pending register (valid, sel, adx); next state WAIT_MEM.
REQ-021 RUN, imem_ready=0, no request: next state WAIT_MEM with the pending register invalid.
REQ-022 WAIT_MEM: PCWr=0; the pending entry is replaced only by a strictly higher-priority request; j/JR are ignored while a branch is pending.
REQ-023 WAIT_MEM with imem_ready=1: PCWr=1, pc_sel/redir_adx from pending (if valid, else from current inputs per REQ-018); pending cleared; next state RUN.
REQ-024 Flushes for a latched redirect SHALL be asserted in the cycle the redirect is latched, not repeated on apply.
REQ-025 haz=1 in RUN with no taken branch: PCWr=0, stall_if_id=1, j/JR ignored; next state HAZ_STALL.
REQ-026 HAZ_STALL: stall_if_id=1 and PCWr=0 while haz=1; return to RUN (or WAIT_MEM if imem_ready=0) on the first cycle haz=0.
REQ-027 A taken branch SHALL override haz in any state: stall_if_id=0, flushes asserted, handled per REQ-018/020.
REQ-028 stall_cnt SHALL increment, saturating at 0xFFFF, on every cycle with PCWr=0 and state not IDLE.
REQ-029 redir_cnt SHALL increment, wrapping modulo 2^16, on every cycle with PCWr=1 and pc_sel not 00.
REQ-030 Branch target SHALL be brAdx as supplied; the offset is added in the PC register, not in this block.

Reset
REQ-031 Asserting reset SHALL asynchronously force state=IDLE, pending invalid, both counters 0; all outputs read 0 while reset is high.
REQ-032 Reset during WAIT_MEM or HAZ_STALL SHALL discard the pending redirect without applying it.

Structure
REQ-033 State encodings and pc_sel constants SHALL live in shared package pc_seq_pkg.
REQ-034 Counters SHALL use one sub-module sat_counter with a parameter selecting saturate or wrap, instantiated twice.

Verification
REQ-035 Reset, then imem_ready=1 for 5 cycles -> IDLE 1 cycle, then PCWr=1 with pc_sel=00 for 4 cycles; stall_cnt=1.
REQ-036 j=1, jAdx=15, and br=1, z=0, brAdx=25 in the same RUN cycle -> pc_sel=11, redir_adx=25, flush_if=flush_id=1, redir_cnt=1.
REQ-037 JR=1, JRAdx=47, imem_ready=0 for 3 cycles, then 1 -> PCWr=0 for 3 cycles, then PCWr=1 with pc_sel=10, redir_adx=47; flush_if only in the first cycle.
REQ-038 haz=1 for 2 cycles with j=1 -> stall_if_id=1, PCWr=0, no redirect; a taken branch in the 2nd cycle -> stall_if_id=0, pc_sel=11.
REQ-039 Pending JR in WAIT_MEM, then a taken branch arrives -> the branch replaces the pending entry, and a later j is ignored; on apply pc_sel=11.
REQ-040 Force 70000 stall cycles -> stall_cnt holds at 0xFFFF; reset mid-WAIT_MEM -> no redirect applied after release.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encodings, PC source selects and redirect record for pc_sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_WAIT_MEM  = 2'b10,
        ST_HAZ_STALL = 2'b11
    } seq_state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_J   = 2'b01;
    localparam logic [1:0] SEL_JR  = 2'b10;
    localparam logic [1:0] SEL_BR  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [1:0]  sel;
        logic [31:0] adx;
    } redir_t;

    // Select encodings are ordered by priority, so a numeric compare ranks them.
    // An invalid entry carries SEL_SEQ and is outranked by any real request.
    function automatic logic outranks(input logic [1:0] a, input logic [1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter with selectable saturate or wrap behaviour
module sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            if (!SATURATE || (count != '1)) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC redirect sequencer: branch/JR/jump arbitration, memory-wait and hazard stalls
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        j,
    input  logic [31:0] jAdx,
    input  logic        JR,
    input  logic [31:0] JRAdx,
    input  logic        br,
    input  logic        z,
    input  logic [31:0] brAdx,
    input  logic        haz,
    input  logic        imem_ready,
    output logic        PCWr,
    output logic [1:0]  pc_sel,
    output logic [31:0] redir_adx,
    output logic        flush_if,
    output logic        flush_id,
    output logic        stall_if_id,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] redir_cnt
);

    seq_state_t state_q, state_next;
    redir_t     pend_q, pend_next;
    redir_t     req, merged;
    logic       taken;

    assign taken = br & ~z;

    // A hazard suppresses j/JR; a taken branch always survives.
    always_comb begin
        req = '0;
        if (taken) begin
            req = '{valid: 1'b1, sel: SEL_BR, adx: brAdx};
        end else if (!haz && JR) begin
            req = '{valid: 1'b1, sel: SEL_JR, adx: JRAdx};
        end else if (!haz && j) begin
            req = '{valid: 1'b1, sel: SEL_J, adx: jAdx};
        end
    end

    always_comb begin
        state_next  = state_q;
        pend_next   = pend_q;
        merged      = pend_q;
        PCWr        = 1'b0;
        pc_sel      = SEL_SEQ;
        redir_adx   = '0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        stall_if_id = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_next = ST_RUN;
            end
            // The first haz-free cycle in HAZ_STALL behaves exactly like RUN.
            ST_RUN, ST_HAZ_STALL: begin
                if (!taken && haz) begin
                    stall_if_id = 1'b1;
                    state_next  = ST_HAZ_STALL;
                end else begin
                    flush_if = req.valid;
                    flush_id = req.valid && (req.sel == SEL_BR);
                    if (imem_ready) begin
                        PCWr       = 1'b1;
                        pc_sel     = req.sel;
                        redir_adx  = req.adx;
                        state_next = ST_RUN;
                    end else begin
                        pend_next  = req;
                        state_next = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // Flushes fire only when an entry is (re)latched, never on apply.
                if (req.valid && outranks(req.sel, pend_q.sel)) begin
                    merged   = req;
                    flush_if = 1'b1;
                    flush_id = (req.sel == SEL_BR);
                end
                if (!taken && haz) begin
                    stall_if_id = 1'b1;
                    pend_next   = merged;
                end else if (imem_ready) begin
                    PCWr       = 1'b1;
                    pc_sel     = merged.sel;
                    redir_adx  = merged.adx;
                    pend_next  = '0;
                    state_next = ST_RUN;
                end else begin
                    pend_next = merged;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_next;
            pend_q  <= pend_next;
        end
    end

    assign state = state_q;

    // Charged against the state being entered, so the IDLE exit bubble counts as a stall.
    sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!PCWr && (state_next != ST_IDLE)),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCWr && (pc_sel != SEL_SEQ)),
        .count (redir_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        j = 1'b0, JR = 1'b0, br = 1'b0, z = 1'b0, haz = 1'b0, imem_ready = 1'b0;
    logic [31:0] jAdx = 32'd15, JRAdx = 32'd47, brAdx = 32'd25;
    logic        PCWr, flush_if, flush_id, stall_if_id;
    logic [1:0]  pc_sel, state;
    logic [31:0] redir_adx;
    logic [15:0] stall_cnt, redir_cnt;
    logic [7:0]  ctl;
    logic [7:0]  exp_ctl;
    int          n_checks = 0;
    int          n_fail = 0;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .j           (j),
        .jAdx        (jAdx),
        .JR          (JR),
        .JRAdx       (JRAdx),
        .br          (br),
        .z           (z),
        .brAdx       (brAdx),
        .haz         (haz),
        .imem_ready  (imem_ready),
        .PCWr        (PCWr),
        .pc_sel      (pc_sel),
        .redir_adx   (redir_adx),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .stall_if_id (stall_if_id),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .redir_cnt   (redir_cnt)
    );

    always #5 clk = ~clk;

    // {PCWr, pc_sel, flush_if, flush_id, stall_if_id, state}
    assign ctl = {PCWr, pc_sel, flush_if, flush_id, stall_if_id, state};

    task automatic drive(input logic j_i, jr_i, br_i, z_i, haz_i, rdy_i);
        j = j_i; JR = jr_i; br = br_i; z = z_i; haz = haz_i; imem_ready = rdy_i;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        repeat (2) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx, stall_cnt, redir_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b adx=%0d stall=%0d redir=%0d, required all 0",
                     ctl, redir_adx, stall_cnt, redir_cnt);
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_ctl = (i == 0) ? 8'b0_00_0_0_0_00 : 8'b1_00_0_0_0_01;
            n_checks++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL startup_cycle%0d: ctl=%b required %b", i, ctl, exp_ctl);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({stall_cnt, redir_cnt} !== {16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL startup_counters: stall=%0d redir=%0d required 1 0", stall_cnt, redir_cnt);
        end
        next_cycle();
    endtask

    task automatic test_priority;
        drive(1, 0, 1, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx} !== {8'b1_11_1_1_0_01, 32'd25}) begin
            n_fail++;
            $display("FAIL br_over_j: ctl=%b adx=%0d required %b 25", ctl, redir_adx, 8'b1_11_1_1_0_01);
        end
        next_cycle();
        drive(1, 0, 1, 1, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx, redir_cnt} !== {8'b1_01_1_0_0_01, 32'd15, 16'd1}) begin
            n_fail++;
            $display("FAIL not_taken_j: ctl=%b adx=%0d redir=%0d required %b 15 1",
                     ctl, redir_adx, redir_cnt, 8'b1_01_1_0_0_01);
        end
        next_cycle();
        drive(1, 1, 0, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx, redir_cnt} !== {8'b1_10_1_0_0_01, 32'd47, 16'd2}) begin
            n_fail++;
            $display("FAIL jr_over_j: ctl=%b adx=%0d redir=%0d required %b 47 2",
                     ctl, redir_adx, redir_cnt, 8'b1_10_1_0_0_01);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx, redir_cnt} !== {8'b1_00_0_0_0_01, 32'd0, 16'd3}) begin
            n_fail++;
            $display("FAIL sequential_after_redirects: ctl=%b adx=%0d redir=%0d required %b 0 3",
                     ctl, redir_adx, redir_cnt, 8'b1_00_0_0_0_01);
        end
        next_cycle();
    endtask

    task automatic test_wait_mem;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            @(negedge clk);
            exp_ctl = (i == 0) ? 8'b0_00_1_0_0_01 : 8'b0_00_0_0_0_10;
            n_checks++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL jr_wait%0d: ctl=%b required %b", i, ctl, exp_ctl);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx} !== {8'b1_10_0_0_0_10, 32'd47}) begin
            n_fail++;
            $display("FAIL jr_apply: ctl=%b adx=%0d required %b 47", ctl, redir_adx, 8'b1_10_0_0_0_10);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({ctl, stall_cnt, redir_cnt} !== {8'b1_00_0_0_0_01, 16'd4, 16'd4}) begin
            n_fail++;
            $display("FAIL after_wait: ctl=%b stall=%0d redir=%0d required %b 4 4",
                     ctl, stall_cnt, redir_cnt, 8'b1_00_0_0_0_01);
        end
        next_cycle();
    endtask

    task automatic test_hazard;
        drive(1, 0, 0, 0, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx} !== {8'b0_00_0_0_1_01, 32'd0}) begin
            n_fail++;
            $display("FAIL haz_drops_j: ctl=%b adx=%0d required %b 0", ctl, redir_adx, 8'b0_00_0_0_1_01);
        end
        next_cycle();
        drive(1, 0, 1, 0, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx} !== {8'b1_11_1_1_0_11, 32'd25}) begin
            n_fail++;
            $display("FAIL br_over_haz: ctl=%b adx=%0d required %b 25", ctl, redir_adx, 8'b1_11_1_1_0_11);
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0_00_0_0_1_01) begin
            n_fail++;
            $display("FAIL haz_again: ctl=%b required %b", ctl, 8'b0_00_0_0_1_01);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0_00_0_0_0_11) begin
            n_fail++;
            $display("FAIL haz_release_not_ready: ctl=%b required %b", ctl, 8'b0_00_0_0_0_11);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, stall_cnt, redir_cnt} !== {8'b1_00_0_0_0_10, 16'd7, 16'd5}) begin
            n_fail++;
            $display("FAIL haz_to_wait_mem: ctl=%b stall=%0d redir=%0d required %b 7 5",
                     ctl, stall_cnt, redir_cnt, 8'b1_00_0_0_0_10);
        end
        next_cycle();
    endtask

    task automatic test_pending_replace;
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0_00_1_0_0_01) begin
            n_fail++;
            $display("FAIL latch_jr: ctl=%b required %b", ctl, 8'b0_00_1_0_0_01);
        end
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0_00_1_1_0_10) begin
            n_fail++;
            $display("FAIL br_replaces_jr: ctl=%b required %b", ctl, 8'b0_00_1_1_0_10);
        end
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0_00_0_0_0_10) begin
            n_fail++;
            $display("FAIL j_ignored_under_br: ctl=%b required %b", ctl, 8'b0_00_0_0_0_10);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx, stall_cnt} !== {8'b1_11_0_0_0_10, 32'd25, 16'd10}) begin
            n_fail++;
            $display("FAIL br_apply: ctl=%b adx=%0d stall=%0d required %b 25 10",
                     ctl, redir_adx, stall_cnt, 8'b1_11_0_0_0_10);
        end
        next_cycle();
    endtask

    task automatic test_saturate_and_reset;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_cnt} !== {8'b0_00_1_0_0_01, 16'd6}) begin
            n_fail++;
            $display("FAIL latch_j: ctl=%b redir=%0d required %b 6", ctl, redir_cnt, 8'b0_00_1_0_0_01);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({ctl, stall_cnt} !== {8'b0_00_0_0_0_10, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL stall_saturate: ctl=%b stall=%h required %b ffff", ctl, stall_cnt, 8'b0_00_0_0_0_10);
        end
        drive(0, 0, 0, 0, 0, 1);
        next_cycle();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({state, stall_cnt, redir_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d stall=%0d redir=%0d required 0 0 0",
                     state, stall_cnt, redir_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({ctl, redir_adx} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: ctl=%b adx=%0d required 0", ctl, redir_adx);
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_ctl = (i == 0) ? 8'b0_00_0_0_0_00 : 8'b1_00_0_0_0_01;
            n_checks++;
            if ({ctl, redir_adx} !== {exp_ctl, 32'd0}) begin
                n_fail++;
                $display("FAIL post_reset%0d: ctl=%b adx=%0d required %b 0", i, ctl, redir_adx, exp_ctl);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({stall_cnt, redir_cnt} !== {16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL post_reset_counters: stall=%0d redir=%0d required 1 0", stall_cnt, redir_cnt);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_wait_mem();
        test_hazard();
        test_pending_replace();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
